// File: rtl/psum_drain.sv
// ----------------------------------------------------------------------------
// psum_drain
//
// Drains a contiguous region of the partial-sum buffer to a downstream
// valid/ready consumer (DMA). A one-cycle start in IDLE latches a base address
// and a word count. Reads are then issued to the buffer's 1-cycle-latency read
// port. Returned words pass through a 2-entry output FIFO, and the FIFO head
// drives the output beat.
//
// Ports
//   clk         clock, all logic on the rising edge
//   rst         synchronous, active-low reset
//   start       one-cycle drain request (honoured in IDLE only)
//   base_addr   first word address, sampled on accepted start
//   word_cnt    number of words to drain (0..2^ADDR_W), sampled on start
//   psum_raddr  buffer read address
//   psum_ren    buffer read strobe, data returns on psum_rdata one cycle later
//   psum_rdata  buffer read data
//   out_valid   out_data/out_last hold a beat
//   out_ready   downstream accepts the beat when out_valid & out_ready
//   out_data    drained word
//   out_last    final beat of the drain
//   busy        high from accepted start until the done cycle completes
//   done        one-cycle pulse after the final beat has been accepted
// ----------------------------------------------------------------------------
module psum_drain #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_cnt,
  output logic [ADDR_W-1:0] psum_raddr,
  output logic              psum_ren,
  input  logic [DATA_W-1:0] psum_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  // Control state
  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   total_q;
  logic [ADDR_W:0]   issue_q;
  logic              busy_q;
  logic              done_q;

  // Read pipeline: a read issued in cycle k has its data on psum_rdata in k+1
  logic              rvalid_q;
  logic              rlast_q;

  // Output FIFO
  logic [DATA_W-1:0] fifo_data_q [2];
  logic [1:0]        fifo_last_q;
  logic              rd_ptr_q;
  logic              wr_ptr_q;
  logic [1:0]        fifo_cnt_q;
  logic [1:0]        fifo_cnt_d;

  logic              fifo_nonempty_s;
  logic              push_s;
  logic              pop_s;
  logic              final_pop_s;
  logic [2:0]        occ_s;
  logic              issue_s;
  logic              last_issue_s;

  // Flow control and read issue decision
  always_comb begin
    fifo_nonempty_s = (fifo_cnt_q != 2'd0);
    push_s          = rvalid_q;
    pop_s           = fifo_nonempty_s & out_ready;
    final_pop_s     = pop_s & fifo_last_q[rd_ptr_q];
    // Occupancy the FIFO will have once this cycle's push/pop settle. A read
    // issued now lands two edges later, so issuing is safe only while this
    // is below the FIFO depth. Crediting the pop in the same cycle is what
    // lets a 2-deep FIFO sustain one beat per cycle.
    occ_s           = {1'b0, fifo_cnt_q} + {2'b00, rvalid_q} - {2'b00, pop_s};
    if (state_q == S_RUN) begin
      issue_s = (occ_s < 3'd2);
    end else begin
      issue_s = 1'b0;
    end
    last_issue_s = issue_s & (issue_q == (total_q - CNT_ONE));
  end

  // FIFO occupancy next state; push and pop together leave it unchanged
  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    case ({push_s, pop_s})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // Drain FSM with address/issue counters and registered busy/done
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= {ADDR_W{1'b0}};
      total_q <= {(ADDR_W+1){1'b0}};
      issue_q <= {(ADDR_W+1){1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            addr_q  <= base_addr;
            total_q <= word_cnt;
            issue_q <= {(ADDR_W+1){1'b0}};
            busy_q  <= 1'b1;
            if (word_cnt == {(ADDR_W+1){1'b0}}) begin
              // Empty region: nothing to read, report completion directly
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RUN;
            end
          end else begin
            busy_q <= 1'b0;
          end
        end
        S_RUN: begin
          if (issue_s) begin
            // Address wraps naturally at the ADDR_W boundary
            addr_q  <= addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            issue_q <= issue_q + CNT_ONE;
            if (last_issue_s) begin
              state_q <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          if (final_pop_s) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Read-return tracking; the last-beat tag travels alongside the read
  always_ff @(posedge clk) begin
    if (!rst) begin
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
    end else begin
      rvalid_q <= issue_s;
      rlast_q  <= last_issue_s;
    end
  end

  // Output FIFO storage and pointers; returned data is pushed in its valid cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= {DATA_W{1'b0}};
      end
      fifo_last_q <= 2'b00;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      fifo_cnt_q  <= 2'd0;
    end else begin
      if (push_s) begin
        fifo_data_q[wr_ptr_q] <= psum_rdata;
        fifo_last_q[wr_ptr_q] <= rlast_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // The head entry is held until accepted, so data/last stay stable under stall
  assign out_valid  = fifo_nonempty_s;
  assign out_data   = fifo_data_q[rd_ptr_q];
  assign out_last   = fifo_last_q[rd_ptr_q] & fifo_nonempty_s;
  assign psum_raddr = addr_q;
  assign psum_ren   = issue_s;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_psum_drain.sv
module tb_psum_drain;
  localparam int AW = 11;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   word_cnt;
  logic [AW-1:0] psum_raddr;
  logic          psum_ren;
  logic [DW-1:0] psum_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Monitor records (written only by the monitor process)
  logic [DW-1:0] bdat[$];
  logic          blast[$];
  int            bcyc[$];
  logic [AW-1:0] rdaddr[$];
  int            done_cnt = 0;
  int            stall_err = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = 32'd0;
  logic          prev_last = 1'b0;

  psum_drain #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .word_cnt   (word_cnt),
    .psum_raddr (psum_raddr),
    .psum_ren   (psum_ren),
    .psum_rdata (psum_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {16'hC0DE, 5'd0, a};
  endfunction

  // Buffer model: synchronous read, garbage when no read was issued
  always @(posedge clk) psum_rdata <= psum_ren ? mem_word(psum_raddr) : 32'hDEAD_BEEF;

  // Monitor: reads, accepted beats, done pulses, stability under stall
  always @(negedge clk) begin
    if (psum_ren) rdaddr.push_back(psum_raddr);
    if (out_valid && out_ready) begin
      bdat.push_back(out_data);
      blast.push_back(out_last);
      bcyc.push_back(cyc);
    end
    if (done) done_cnt <= done_cnt + 1;
    if (rst && prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last))
      stall_err <= stall_err + 1;
    prev_stall <= rst && out_valid && !out_ready;
    prev_data  <= out_data;
    prev_last  <= out_last;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [AW-1:0] b, input logic [AW:0] n, output int t0);
    base_addr = b;
    word_cnt  = n;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    base_addr = ~b;          // must have been sampled already
    word_cnt  = 12'd5;
    t0        = cyc;
  endtask

  task automatic wait_done(input string tag, output int dcyc);
    int n = 0;
    while (done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, {63'd0, done}, 64'd1);
    dcyc = cyc;
  endtask

  task automatic check_beats(input string tag, input int b0, input int r0,
                             input logic [AW-1:0] b, input int n);
    logic [AW-1:0] ea;
    chk({tag, "_beats"}, bdat.size() - b0, n);
    chk({tag, "_reads"}, rdaddr.size() - r0, n);
    for (int i = 0; i < n; i++) begin
      ea = b + i[AW-1:0];
      chk($sformatf("%s_addr%0d", tag, i), rdaddr[r0+i], ea);
      chk($sformatf("%s_data%0d", tag, i), bdat[b0+i], mem_word(ea));
      chk($sformatf("%s_last%0d", tag, i), blast[b0+i], (i == n - 1) ? 1 : 0);
    end
  endtask

  initial begin
    int t0, dc, b0, r0, d0, n;
    logic [15:0] pat;
    rst = 1'b0; start = 1'b0; base_addr = 11'd0; word_cnt = 12'd0; out_ready = 1'b1;
    pat = 16'b1011_0010_1101_0110;

    // Reset state
    tick(); tick(); tick();
    chk("rst_raddr", psum_raddr, 0);
    chk("rst_ren", psum_ren, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b1;
    tick();

    // Basic drain with out_ready high: back-to-back beats, fixed latency
    b0 = bdat.size(); r0 = rdaddr.size(); d0 = done_cnt;
    launch(11'h010, 12'd4, t0);
    chk("t1_busy", busy, 1);
    wait_done("t1", dc);
    check_beats("t1", b0, r0, 11'h010, 4);
    chk("t1_first_beat_cyc", bcyc[b0], t0 + 2);
    chk("t1_last_beat_cyc", bcyc[b0+3], t0 + 5);
    chk("t1_done_cyc", dc, t0 + 6);
    chk("t1_done_busy", busy, 1);
    tick();
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_done", done, 0);
    chk("t1_done_count", done_cnt - d0, 1);

    // Address wrap at the top of the buffer
    b0 = bdat.size(); r0 = rdaddr.size();
    launch(11'h7FE, 12'd4, t0);
    wait_done("t2", dc);
    check_beats("t2", b0, r0, 11'h7FE, 4);
    tick();

    // Irregular backpressure
    b0 = bdat.size(); r0 = rdaddr.size();
    launch(11'h040, 12'd8, t0);
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      out_ready = pat[n % 16];
      tick();
      n++;
    end
    out_ready = 1'b1;
    chk("t3_done_seen", done, 1);
    check_beats("t3", b0, r0, 11'h040, 8);
    chk("t3_stall_stable", stall_err, 0);
    tick();

    // Full stall: reads stop once FIFO plus in-flight reach two
    b0 = bdat.size(); r0 = rdaddr.size();
    out_ready = 1'b0;
    launch(11'h080, 12'd3, t0);
    for (int i = 0; i < 10; i++) tick();
    chk("t7_reads_stalled", rdaddr.size() - r0, 2);
    chk("t7_valid", out_valid, 1);
    chk("t7_head", out_data, mem_word(11'h080));
    chk("t7_last", out_last, 0);
    chk("t7_busy", busy, 1);
    out_ready = 1'b1;
    wait_done("t7", dc);
    check_beats("t7", b0, r0, 11'h080, 3);
    chk("t7_stall_stable", stall_err, 0);
    tick();

    // Zero-length drain
    b0 = bdat.size(); r0 = rdaddr.size(); d0 = done_cnt;
    launch(11'h055, 12'd0, t0);
    chk("t4_busy", busy, 1);
    chk("t4_done", done, 1);
    chk("t4_ren", psum_ren, 0);
    chk("t4_valid", out_valid, 0);
    tick();
    chk("t4_busy_after", busy, 0);
    chk("t4_done_after", done, 0);
    chk("t4_reads", rdaddr.size() - r0, 0);
    chk("t4_beats", bdat.size() - b0, 0);
    chk("t4_done_count", done_cnt - d0, 1);

    // Reset in the middle of a drain
    b0 = bdat.size();
    launch(11'h100, 12'd16, t0);
    n = 0;
    while (bdat.size() - b0 < 3 && n < 100) begin
      tick();
      n++;
    end
    chk("t5_reached_beat3", (bdat.size() - b0 >= 3) ? 1 : 0, 1);
    d0 = done_cnt;
    rst = 1'b0;
    tick();
    chk("t5_raddr", psum_raddr, 0);
    chk("t5_ren", psum_ren, 0);
    chk("t5_valid", out_valid, 0);
    chk("t5_data", out_data, 0);
    chk("t5_last", out_last, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("t5_no_done", done_cnt - d0, 0);
    chk("t5_idle_busy", busy, 0);
    b0 = bdat.size(); r0 = rdaddr.size();
    launch(11'h000, 12'd2, t0);
    wait_done("t5b", dc);
    check_beats("t5b", b0, r0, 11'h000, 2);
    tick();

    // Start while busy is ignored, including in the done cycle
    b0 = bdat.size(); r0 = rdaddr.size(); d0 = done_cnt;
    launch(11'h020, 12'd4, t0);
    tick();
    base_addr = 11'h300; word_cnt = 12'd2; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t6", dc);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check_beats("t6", b0, r0, 11'h020, 4);
    chk("t6_done_count", done_cnt - d0, 1);
    chk("t6_busy_after", busy, 0);
    chk("t6_valid_after", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
